bidir_bus_ctrl: RTL



---
 rtl/bidir_bus_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex tristate bus sequencer: arbitrates a write port and a read port
// onto a shared IO buffer, inserting turnaround gaps before driving the pins.
module bidir_bus_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TURN_CYC   = 2,
  parameter int WR_CYC     = 1,
  parameter int RD_CYC     = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  bus_dir,
  output logic [DATA_WIDTH-1:0] bus_dout,
  input  logic [DATA_WIDTH-1:0] bus_din,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, W_TURN, W_DRIVE, R_WAIT} state_e;
  typedef enum logic {GRANT_WRITE, GRANT_READ} grant_e;
  typedef enum logic {OP_WRITE, OP_READ} op_e;

  // Counters hold "cycles remaining minus one", so a state exits when it reads zero.
  localparam logic [7:0] TURN_LD = 8'(TURN_CYC - 1);
  localparam logic [7:0] WR_LD   = 8'(WR_CYC - 1);
  localparam logic [7:0] RD_LD   = 8'(RD_CYC - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  grant_e                last_grant_q, last_grant_d;
  op_e                   last_op_q, last_op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bus_dir_q, bus_dir_d;
  logic [DATA_WIDTH-1:0] bus_dout_q, bus_dout_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_accept, rd_accept;

  // On a tie the requester that did not win last time gets the bus.
  assign wr_accept = (state_q == IDLE) && wr_valid && (!rd_req || last_grant_q == GRANT_READ);
  assign rd_accept = (state_q == IDLE) && rd_req && (!wr_valid || last_grant_q == GRANT_WRITE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    last_op_d    = last_op_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_accept) begin
          wdata_d      = wr_data;
          last_grant_d = GRANT_WRITE;
          last_op_d    = OP_WRITE;
          if (last_op_q == OP_WRITE) begin
            state_d = W_DRIVE;
            cnt_d   = WR_LD;
          end else begin
            state_d = W_TURN;
            cnt_d   = TURN_LD;
          end
        end else if (rd_accept) begin
          last_grant_d = GRANT_READ;
          last_op_d    = OP_READ;
          state_d      = R_WAIT;
          cnt_d        = RD_LD;
        end
      end
      W_TURN: begin
        if (cnt_q == 8'd0) begin
          state_d = W_DRIVE;
          cnt_d   = WR_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      W_DRIVE: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      R_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d    = IDLE;
          cnt_d      = 8'd0;
          rd_data_d  = bus_din;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // Pin controls are registered from the next state so they line up with it.
    bus_dir_d  = (state_d != W_DRIVE);
    bus_dout_d = (state_d == W_DRIVE) ? wdata_d : bus_dout_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= GRANT_WRITE;
      last_op_q    <= OP_READ;
      wdata_q      <= '0;
      bus_dir_q    <= 1'b1;
      bus_dout_q   <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      last_op_q    <= last_op_d;
      wdata_q      <= wdata_d;
      bus_dir_q    <= bus_dir_d;
      bus_dout_q   <= bus_dout_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign wr_ready = wr_accept;
  assign rd_ack   = rd_accept;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign bus_dir  = bus_dir_q;
  assign bus_dout = bus_dout_q;
  assign busy     = (state_q != IDLE);

endmodule
